// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller beside decode: keeps an EX/MEM destination scoreboard
// and drives the PC / IF-ID / ID-EX hold, flush and freeze controls.
module hazard_stall_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16,
    parameter int FORWARDING  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_busy,
    output logic                   stall,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   pipe_freeze,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam bit NoFwd = (FORWARDING == 0);

    logic [REG_ADDR_W-1:0]  ex_rd_q, ex_rd_d;
    logic                   ex_regwrite_q, ex_regwrite_d;
    logic                   ex_memread_q, ex_memread_d;
    logic [REG_ADDR_W-1:0]  mem_rd_q;
    logic                   mem_regwrite_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic match_ex;
    logic match_mem;
    logic hazard;

    // x0 is never a real producer, so a zero destination cannot match.
    assign match_ex  = ex_regwrite_q && (ex_rd_q != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd_q)));
    assign match_mem = mem_regwrite_q && (mem_rd_q != '0) &&
                       ((id_uses_rs1 && (id_rs1 == mem_rd_q)) ||
                        (id_uses_rs2 && (id_rs2 == mem_rd_q)));
    assign hazard    = id_valid && ((match_ex && ex_memread_q) ||
                                    (NoFwd && (match_ex || match_mem)));

    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst_n) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (dmem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            // The hazarding instruction in ID is squashed, so the redirect wins.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hazard) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_comb begin
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        if (id_valid && !stall && !ex_branch_taken) begin
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // A frozen pipeline (dmem_busy) holds both scoreboard and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else if (!dmem_busy) begin
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: forwarding, no-forwarding and 3-bit counter
// instances share one set of stimulus inputs.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic       ex_branch_taken, dmem_busy;

    logic        f_stall, f_pc_write, f_ifid_write, f_ifid_flush, f_idex_flush, f_pipe_freeze;
    logic [15:0] f_stall_count;
    logic        n_stall, n_pc_write, n_ifid_write, n_ifid_flush, n_idex_flush, n_pipe_freeze;
    logic [15:0] n_stall_count;
    logic        c_stall, c_pc_write, c_ifid_write, c_ifid_flush, c_idex_flush, c_pipe_freeze;
    logic [2:0]  c_stall_count;

    int tests_run;
    int tests_failed;

    hazard_stall_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16), .FORWARDING(1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .stall(f_stall), .pc_write(f_pc_write), .ifid_write(f_ifid_write),
        .ifid_flush(f_ifid_flush), .idex_flush(f_idex_flush), .pipe_freeze(f_pipe_freeze),
        .stall_count(f_stall_count)
    );

    hazard_stall_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16), .FORWARDING(0)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .stall(n_stall), .pc_write(n_pc_write), .ifid_write(n_ifid_write),
        .ifid_flush(n_ifid_flush), .idex_flush(n_idex_flush), .pipe_freeze(n_pipe_freeze),
        .stall_count(n_stall_count)
    );

    hazard_stall_unit #(.REG_ADDR_W(5), .STALL_CNT_W(3), .FORWARDING(1)) u_cnt3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .stall(c_stall), .pc_write(c_pc_write), .ifid_write(c_ifid_write),
        .ifid_flush(c_ifid_flush), .idex_flush(c_idex_flush), .pipe_freeze(c_pipe_freeze),
        .stall_count(c_stall_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = rs1;
        id_uses_rs1 = u1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic idle();
        ex_branch_taken = 1'b0;
        dmem_busy       = 1'b0;
        set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tests_run++; if (f_stall !== 1'b1) begin tests_failed++; $display("FAIL rst_stall got %0b exp 1", f_stall); end
        tests_run++; if (f_pc_write !== 1'b0) begin tests_failed++; $display("FAIL rst_pc_write got %0b exp 0", f_pc_write); end
        tests_run++; if (f_ifid_write !== 1'b0) begin tests_failed++; $display("FAIL rst_ifid_write got %0b exp 0", f_ifid_write); end
        tests_run++; if ({f_ifid_flush, f_idex_flush, f_pipe_freeze} !== 3'b000) begin tests_failed++; $display("FAIL rst_flush_freeze got %b exp 000", {f_ifid_flush, f_idex_flush, f_pipe_freeze}); end
        step();
        tests_run++; if (f_stall_count !== 16'd0) begin tests_failed++; $display("FAIL rst_count got %0d exp 0", f_stall_count); end
        rst_n = 1'b1;
        #1;
        tests_run++; if ({f_stall, f_pc_write, f_ifid_write} !== 3'b011) begin tests_failed++; $display("FAIL rst_release got %b exp 011", {f_stall, f_pc_write, f_ifid_write}); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tests_run++; if (f_stall !== 1'b0) begin tests_failed++; $display("FAIL lu_load_issue stall got %0b exp 0", f_stall); end
        step();
        set_instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);   // add x6, x5, ...
        tests_run++; if ({f_stall, f_pc_write, f_ifid_write} !== 3'b100) begin tests_failed++; $display("FAIL lu_stall got %b exp 100", {f_stall, f_pc_write, f_ifid_write}); end
        tests_run++; if (f_stall_count !== 16'd0) begin tests_failed++; $display("FAIL lu_count_before got %0d exp 0", f_stall_count); end
        step();
        tests_run++; if ({f_stall, f_pc_write, f_ifid_write} !== 3'b011) begin tests_failed++; $display("FAIL lu_release got %b exp 011", {f_stall, f_pc_write, f_ifid_write}); end
        tests_run++; if (f_stall_count !== 16'd1) begin tests_failed++; $display("FAIL lu_count_after got %0d exp 1", f_stall_count); end
        step();
        idle();
        tests_run++; if (f_stall_count !== 16'd1) begin tests_failed++; $display("FAIL lu_count_hold got %0d exp 1", f_stall_count); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
        step();
        set_instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        tests_run++; if (f_stall !== 1'b0) begin tests_failed++; $display("FAIL nh_x0 stall got %0b exp 0", f_stall); end
        tests_run++; if (n_stall !== 1'b0) begin tests_failed++; $display("FAIL nh_x0_nofwd stall got %0b exp 0", n_stall); end
        step();
        set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        step();
        set_instr(1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);   // rs2=x5 not read
        tests_run++; if (f_stall !== 1'b0) begin tests_failed++; $display("FAIL nh_unused_rs2 stall got %0b exp 0", f_stall); end
        step();
        idle();
        tests_run++; if (f_stall_count !== 16'd0) begin tests_failed++; $display("FAIL nh_count got %0d exp 0", f_stall_count); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        step();
        ex_branch_taken = 1'b1;
        set_instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        tests_run++; if ({f_stall, f_pc_write, f_ifid_write} !== 3'b011) begin tests_failed++; $display("FAIL br_stall_pc got %b exp 011", {f_stall, f_pc_write, f_ifid_write}); end
        tests_run++; if ({f_ifid_flush, f_idex_flush, f_pipe_freeze} !== 3'b110) begin tests_failed++; $display("FAIL br_flush got %b exp 110", {f_ifid_flush, f_idex_flush, f_pipe_freeze}); end
        step();
        ex_branch_taken = 1'b0;
        #1;
        tests_run++; if ({f_stall, f_ifid_flush, f_idex_flush} !== 3'b000) begin tests_failed++; $display("FAIL br_next got %b exp 000", {f_stall, f_ifid_flush, f_idex_flush}); end
        step();
        idle();
    endtask

    task automatic test_dmem_busy();
        do_reset();
        set_instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        step();
        dmem_busy = 1'b1;
        set_instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if ({f_pipe_freeze, f_stall, f_pc_write, f_ifid_write} !== 4'b1000) begin tests_failed++; $display("FAIL busy_freeze[%0d] got %b exp 1000", i, {f_pipe_freeze, f_stall, f_pc_write, f_ifid_write}); end
            step();
        end
        dmem_busy = 1'b0;
        #1;
        tests_run++; if ({f_pipe_freeze, f_stall} !== 2'b01) begin tests_failed++; $display("FAIL busy_resume got %b exp 01", {f_pipe_freeze, f_stall}); end
        tests_run++; if (f_stall_count !== 16'd0) begin tests_failed++; $display("FAIL busy_count_before got %0d exp 0", f_stall_count); end
        step();
        tests_run++; if (f_stall !== 1'b0) begin tests_failed++; $display("FAIL busy_after stall got %0b exp 0", f_stall); end
        tests_run++; if (f_stall_count !== 16'd1) begin tests_failed++; $display("FAIL busy_count_after got %0d exp 1", f_stall_count); end
        step();
        idle();
    endtask

    task automatic test_no_forwarding();
        do_reset();
        set_instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7
        step();
        set_instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // reader of x7
        tests_run++; if (n_stall !== 1'b1) begin tests_failed++; $display("FAIL nf_ex_stall1 got %0b exp 1", n_stall); end
        tests_run++; if (f_stall !== 1'b0) begin tests_failed++; $display("FAIL nf_fwd_no_stall got %0b exp 0", f_stall); end
        step();
        tests_run++; if (n_stall !== 1'b1) begin tests_failed++; $display("FAIL nf_ex_stall2 got %0b exp 1", n_stall); end
        step();
        tests_run++; if (n_stall !== 1'b0) begin tests_failed++; $display("FAIL nf_ex_release got %0b exp 0", n_stall); end
        step();
        idle();
        tests_run++; if (n_stall_count !== 16'd2) begin tests_failed++; $display("FAIL nf_ex_count got %0d exp 2", n_stall_count); end

        do_reset();
        set_instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7
        step();
        set_instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // unrelated
        tests_run++; if (n_stall !== 1'b0) begin tests_failed++; $display("FAIL nf_unrelated got %0b exp 0", n_stall); end
        step();
        set_instr(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);   // reads x7 via rs2
        tests_run++; if (n_stall !== 1'b1) begin tests_failed++; $display("FAIL nf_mem_stall got %0b exp 1", n_stall); end
        step();
        tests_run++; if (n_stall !== 1'b0) begin tests_failed++; $display("FAIL nf_mem_release got %0b exp 0", n_stall); end
        step();
        idle();
        tests_run++; if (n_stall_count !== 16'd1) begin tests_failed++; $display("FAIL nf_mem_count got %0d exp 1", n_stall_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        // A load of x5 that also reads x5: stalls on every second cycle.
        set_instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tests_run++; if (c_stall !== 1'(k % 2)) begin tests_failed++; $display("FAIL sat_stall[%0d] got %0b exp %0b", k, c_stall, 1'(k % 2)); end
            step();
        end
        tests_run++; if (c_stall_count !== 3'd7) begin tests_failed++; $display("FAIL sat_count got %0d exp 7", c_stall_count); end
        step();
        tests_run++; if (c_stall !== 1'b1) begin tests_failed++; $display("FAIL sat_midstall got %0b exp 1", c_stall); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (c_stall_count !== 3'd0) begin tests_failed++; $display("FAIL sat_rst_count got %0d exp 0", c_stall_count); end
        tests_run++; if ({c_stall, c_pc_write} !== 2'b10) begin tests_failed++; $display("FAIL sat_rst_ctrl got %b exp 10", {c_stall, c_pc_write}); end
        step();
        tests_run++; if ({c_stall, c_pc_write, c_stall_count} !== 5'b10000) begin tests_failed++; $display("FAIL sat_rst_hold got %b exp 10000", {c_stall, c_pc_write, c_stall_count}); end
        rst_n = 1'b1;
        #1;
        tests_run++; if ({c_stall, c_pc_write} !== 2'b01) begin tests_failed++; $display("FAIL sat_rst_release got %b exp 01", {c_stall, c_pc_write}); end
        step();
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_dmem_busy();
        test_no_forwarding();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
